// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit: the default register /
// PC width, the default first fetch address and the fetch FSM state type.
// ---------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned RV_DEFAULT       = 32;
   localparam logic [63:0] RESET_PC_DEFAULT = 64'h0;

   // IDLE    : no request on the memory port
   // REQ     : request outstanding, returned halfword goes into the queue
   // DISCARD : request outstanding, but a redirect made its data stale
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DISCARD
   } fetch_state_t;

endpackage : fetch_pkg

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// DEPTH-entry FIFO of {pc, instruction halfword} pairs between the memory
// port and decode.
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   flush              empty the queue at the edge (wins over push/pop)
//   push, push_pc/ins  write an entry at the tail
//   pop                remove the head entry at the edge
//   count              number of valid entries
//   empty              count == 0
//   head_pc, head_ins  head entry, forced to 0 while the queue is empty
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned RV    = RV_DEFAULT,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned PW   = $clog2(DEPTH),
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   input  logic          push,
   input  logic [RV-1:0] push_pc,
   input  logic [15:0]   push_ins,
   input  logic          pop,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic [RV-1:0] head_pc,
   output logic [15:0]   head_ins
);

   logic [RV-1:0] pc_mem  [DEPTH];
   logic [15:0]   ins_mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;

   // Pointers wrap modulo DEPTH, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // NOTE: the storage array has no reset; an entry is only ever read after
   // it has been written, and the head outputs are masked while empty.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         pc_mem[wr_ptr]  <= push_pc;
         ins_mem[wr_ptr] <= push_ins;
      end
   end

   // NOTE: state registers use non-blocking assignments and reset
   // asynchronously, so every register sees the pre-edge value of the others.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign empty    = (count == '0);
   assign head_pc  = empty ? '0 : pc_mem[rd_ptr];
   assign head_ins = empty ? '0 : ins_mem[rd_ptr];

endmodule : fetch_queue

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch
// Instruction fetch unit: issues one halfword request at a time to
// instruction memory, buffers returned halfwords in a small prefetch queue
// and presents the queue head to decode.
//
// Ports
//   clk, reset     clock, asynchronous active-high reset
//   mem_req        registered memory request
//   mem_addr       halfword request address (bit 0 always 0)
//   mem_ack        request completes when mem_req & mem_ack
//   mem_rdata      returned halfword, valid with mem_ack
//   stall          decode cannot accept an instruction this cycle
//   redirect       one-cycle pulse, fetch restarts at redirect_pc
//   redirect_pc    new fetch target (bit 0 ignored)
//   ins, ipc       queue head instruction and its address
//   idone          decode takes the head this cycle (popped at the edge)
// ---------------------------------------------------------------------------
module fetch
   import fetch_pkg::*;
#(
   parameter int unsigned   RV       = RV_DEFAULT,
   parameter logic [RV-1:0] RESET_PC = RV'(RESET_PC_DEFAULT),
   parameter int unsigned   DEPTH    = 2
) (
   input  logic          clk,
   input  logic          reset,
   output logic          mem_req,
   output logic [RV-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [15:0]   mem_rdata,
   input  logic          stall,
   input  logic          redirect,
   input  logic [RV-1:0] redirect_pc,
   output logic [15:0]   ins,
   output logic [RV-1:0] ipc,
   output logic          idone
);

   localparam int unsigned   CW         = $clog2(DEPTH + 1);
   localparam logic [RV-1:0] RESET_ADDR = {RESET_PC[RV-1:1], 1'b0};

   fetch_state_t  state;
   logic [RV-1:0] fetch_pc;   // next address to request
   logic [RV-1:0] target;
   logic          unused_target_lsb;

   logic          q_push;
   logic          q_empty;
   logic [CW-1:0] q_count;
   logic [CW-1:0] cnt_after_pop;
   logic          room_idle;
   logic          room_after_push;

   assign target            = {redirect_pc[RV-1:1], 1'b0};
   assign unused_target_lsb = redirect_pc[0];

   // Redirect overrides stall and kills the current head.
   assign idone = !q_empty && !stall && !redirect;

   // Only a non-stale ack in REQ writes the queue.
   assign q_push = (state == S_REQ) && mem_ack && !redirect;

   // Occupancy seen by the next cycle. A request may be issued only if the
   // entries left after this edge plus the new outstanding request fit.
   assign cnt_after_pop   = q_count - CW'(idone);
   assign room_idle       = cnt_after_pop < CW'(DEPTH);
   assign room_after_push = (cnt_after_pop + CW'(1)) < CW'(DEPTH);

   fetch_queue #(
      .RV    (RV),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect),
      .push     (q_push),
      .push_pc  (mem_addr),
      .push_ins (mem_rdata),
      .pop      (idone),
      .count    (q_count),
      .empty    (q_empty),
      .head_pc  (ipc),
      .head_ins (ins)
   );

   // mem_req is high exactly in REQ and DISCARD, so mem_ack alone marks a
   // completing request in those states.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         mem_req  <= 1'b0;
         mem_addr <= RESET_ADDR;
         fetch_pc <= RESET_ADDR;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect) begin
                  // Queue is flushed at this edge, so there is always room.
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= target;
                  fetch_pc <= target + RV'(2);
               end else if (room_idle) begin
                  state    <= S_REQ;
                  mem_req  <= 1'b1;
                  mem_addr <= fetch_pc;
                  fetch_pc <= fetch_pc + RV'(2);
               end
            end

            S_REQ: begin
               if (redirect) begin
                  if (mem_ack) begin
                     // Completing data is dropped; start the target at once.
                     mem_addr <= target;
                     fetch_pc <= target + RV'(2);
                  end else begin
                     // Request must stay stable until acked; remember target.
                     state    <= S_DISCARD;
                     fetch_pc <= target;
                  end
               end else if (mem_ack) begin
                  if (room_after_push) begin
                     mem_addr <= fetch_pc;
                     fetch_pc <= fetch_pc + RV'(2);
                  end else begin
                     state   <= S_IDLE;
                     mem_req <= 1'b0;
                  end
               end
            end

            S_DISCARD: begin
               if (mem_ack) begin
                  // Stale data dropped; queue is empty, issue the target.
                  state <= S_REQ;
                  if (redirect) begin
                     mem_addr <= target;
                     fetch_pc <= target + RV'(2);
                  end else begin
                     mem_addr <= fetch_pc;
                     fetch_pc <= fetch_pc + RV'(2);
                  end
               end else if (redirect) begin
                  fetch_pc <= target;
               end
            end

            default: begin
               state   <= S_IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule : fetch
